ca_line_sched: RTL and testbench
================================

// Module: ca_line_sched
// PURPOSE
//  Schedules refills of the CA line buffer, one line per display line. On each line request it
//  grants one of two CA generators, pulses that generator's start and forwards its
//  160-word write burst into the back bank of a ping-pong buffer. After a complete burst it
//  swaps banks so the display reads the fresh line. Sits between display timing, ca_gen* blocks and line RAM.
// PARAMETERS
//  WORDS    160  words per line; a burst is complete after WORDS accepted writes
//  AW       8    generator word-address width
//  DW       16   data width
//  TIMEOUT  255  max idle cycles between writes in FILL before abort
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  line_req   in   1      1-cycle pulse from display timing: fill next line
//  sel_mode   in   1      0 = fixed (gen_sel), 1 = round-robin per completed line
//  gen_sel    in   1      generator index used when sel_mode=0
//  start0/1   out  1      start pulse to generator 0/1
//  write0/1   in   1      generator write strobe
//  waddr0/1   in   AW     generator word address
//  wdata0/1   in   DW     generator data
//  mem_we     out  1      line RAM write enable
//  mem_addr   out  AW+1   {wr_bank, word address}
//  mem_wdata  out  DW     line RAM write data
//  rd_bank    out  1      bank the display reads; write bank is ~rd_bank
//  busy       out  1      high in START/FILL/SWAP
//  done       out  1      1-cycle pulse on bank swap
//  overrun    out  1      1-cycle pulse: line_req arrived while busy (request dropped)
//  timeout    out  1      1-cycle pulse: burst aborted on TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0, rd_bank=0, rr pointer=0, word count=0, state IDLE.
//  FSM IDLE -> START -> FILL -> SWAP -> IDLE.
//  IDLE: on line_req latch grant g = sel_mode ? rr : gen_sel; clear count and idle counter; -> START.
//  START: start_g=1 for exactly this cycle; other start stays 0; -> FILL.
//  FILL: write_g with waddr_g < WORDS: next cycle mem_we=1, mem_addr={~rd_bank,waddr_g},
//    mem_wdata=wdata_g (1-cycle registered latency); count++; idle counter cleared.
//    write_g with waddr_g >= WORDS: dropped, not counted, idle counter still cleared.
//    Writes from non-granted generator always ignored; no mem_we in any other state.
//    count reaches WORDS -> SWAP. Idle counter reaches TIMEOUT -> timeout pulse, -> IDLE,
//    no swap, rr unchanged.
//  SWAP: rd_bank toggles, done=1 this cycle, rr toggles if sel_mode=1; -> IDLE.
//  line_req in any state but IDLE (incl. the SWAP cycle) -> overrun pulse, request discarded.
//  Count is $clog2(WORDS+1) bits; no wrap: it saturates at WORDS, since FSM leaves FILL.
//  Generator mem writes for a line land only in the non-displayed bank.
//  Reset mid-burst: asynchronous return to reset values; partial line never swapped in.
//  gen_sel/sel_mode sampled only on line_req in IDLE; mid-burst changes take effect next line.
// STRUCTURE
//  Shared package ca_pkg: CA_WORDS=160, CA_AW=8, CA_DW=16, state encoding localparams
//  (IDLE, START, FILL, SWAP). One sub-module: ca_wr_mux: grant-selected write port, registers
//  mem_we/mem_addr/mem_wdata, flags range. FSM, counters and bank/rr state remain in ca_line_sched.
// TESTING
//  1 Reset, sel_mode=0, gen_sel=0, line_req; gen0 writes addr 0..159 -> start0 1 cycle,
//    160 mem_we at {1,addr}, done once, rd_bank 0->1, start1 never high.
//  2 sel_mode=1, three line_req each after done -> grants 0,1,0; bank addr MSB 1,0,1.
//  3 line_req during FILL and on the SWAP cycle -> overrun pulse each, no extra start.
//  4 Granted gen stops after 100 writes -> timeout after 255 idle cycles, rd_bank unchanged, next
//    line_req grants same gen in RR mode.
//  5 Non-granted gen writes in FILL, granted gen writes addr 200 -> no mem_we for either, count unchanged.
//  6 rst_n low after 80 writes -> outputs 0 immediately, rd_bank=0, no done.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared constants and FSM state type for the CA line refill scheduler.
package ca_pkg;
  localparam int CA_WORDS   = 160;
  localparam int CA_AW      = 8;
  localparam int CA_DW      = 16;
  localparam int CA_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_FILL,
    ST_SWAP
  } ca_state_e;
endpackage

// File: rtl/ca_line_sched_if.sv
// Bundles display-timing, generator and line-RAM signals of the CA line scheduler.
interface ca_line_sched_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          line_req;
  logic          sel_mode;
  logic          gen_sel;
  logic          start0;
  logic          start1;
  logic          write0;
  logic          write1;
  logic [AW-1:0] waddr0;
  logic [AW-1:0] waddr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          rd_bank;
  logic          busy;
  logic          done;
  logic          overrun;
  logic          timeout;

  modport slave (
    input  line_req, sel_mode, gen_sel, write0, write1, waddr0, waddr1, wdata0, wdata1,
    output start0, start1, mem_we, mem_addr, mem_wdata, rd_bank, busy, done, overrun, timeout
  );

  modport master (
    output line_req, sel_mode, gen_sel, write0, write1, waddr0, waddr1, wdata0, wdata1,
    input  start0, start1, mem_we, mem_addr, mem_wdata, rd_bank, busy, done, overrun, timeout
  );
endinterface

// File: rtl/ca_wr_mux.sv
// Selects the granted generator's write port, range-checks it and registers the line-RAM write.
module ca_wr_mux #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int WORDS = 160
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_gnt,
  input  logic          i_bank,
  input  logic          i_write0,
  input  logic          i_write1,
  input  logic [AW-1:0] i_waddr0,
  input  logic [AW-1:0] i_waddr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_hit,
  output logic          o_in_range,
  output logic          o_mem_we,
  output logic [AW:0]   o_mem_addr,
  output logic [DW-1:0] o_mem_wdata
);
  localparam logic [AW:0] LP_WORDS = (AW+1)'(WORDS);

  logic          w_write;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_acc;
  logic          r_we;
  logic [AW:0]   r_addr;
  logic [DW-1:0] r_data;

  assign w_write    = i_gnt ? i_write1 : i_write0;
  assign w_addr     = i_gnt ? i_waddr1 : i_waddr0;
  assign w_data     = i_gnt ? i_wdata1 : i_wdata0;
  assign o_hit      = i_en & w_write;
  assign o_in_range = ({1'b0, w_addr} < LP_WORDS);
  assign w_acc      = o_hit & o_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_acc;
      if (w_acc) begin
        r_addr <= {i_bank, w_addr};
        r_data <= w_data;
      end
    end
  end

  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_data;
endmodule

// File: rtl/ca_line_sched.sv
// Per-line refill scheduler: grants a CA generator, forwards its burst into the back bank, swaps banks.
module ca_line_sched
  import ca_pkg::*;
#(
  parameter int WORDS   = CA_WORDS,
  parameter int AW      = CA_AW,
  parameter int DW      = CA_DW,
  parameter int TIMEOUT = CA_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  ca_line_sched_if.slave  bus
);
  localparam int CW = $clog2(WORDS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LP_WORDS     = CW'(WORDS);
  localparam logic [IW-1:0] LP_IDLE_LAST = IW'(TIMEOUT - 1);

  ca_state_e     r_state;
  logic          r_gnt, r_mode, r_rr, r_bank;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idle;
  logic          r_start0, r_start1, r_busy, r_done, r_over, r_to;
  logic          w_pick, w_en, w_hit, w_in_range;

  assign w_pick = bus.sel_mode ? r_rr : bus.gen_sel;
  // Accepting stops once the count is full so the count never exceeds WORDS.
  assign w_en   = (r_state == ST_FILL) && (r_cnt != LP_WORDS);

  ca_wr_mux #(.AW(AW), .DW(DW), .WORDS(WORDS)) u_wr_mux (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_en),
    .i_gnt      (r_gnt),
    .i_bank     (~r_bank),
    .i_write0   (bus.write0),
    .i_write1   (bus.write1),
    .i_waddr0   (bus.waddr0),
    .i_waddr1   (bus.waddr1),
    .i_wdata0   (bus.wdata0),
    .i_wdata1   (bus.wdata1),
    .o_hit      (w_hit),
    .o_in_range (w_in_range),
    .o_mem_we   (bus.mem_we),
    .o_mem_addr (bus.mem_addr),
    .o_mem_wdata(bus.mem_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 1'b0;
      r_mode   <= 1'b0;
      r_rr     <= 1'b0;
      r_bank   <= 1'b0;
      r_cnt    <= '0;
      r_idle   <= '0;
      r_start0 <= 1'b0;
      r_start1 <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_over   <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_start0 <= 1'b0;
      r_start1 <= 1'b0;
      r_done   <= 1'b0;
      r_to     <= 1'b0;
      r_over   <= bus.line_req && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (bus.line_req) begin
            r_gnt    <= w_pick;
            r_mode   <= bus.sel_mode;
            r_cnt    <= '0;
            r_idle   <= '0;
            r_start0 <= ~w_pick;
            r_start1 <= w_pick;
            r_busy   <= 1'b1;
            r_state  <= ST_START;
          end
        end
        ST_START: r_state <= ST_FILL;
        ST_FILL: begin
          if (r_cnt == LP_WORDS) begin
            r_state <= ST_SWAP;
            r_bank  <= ~r_bank;
            r_done  <= 1'b1;
            if (r_mode) r_rr <= ~r_rr;
          end else if (w_hit) begin
            r_idle <= '0;
            if (w_in_range) r_cnt <= r_cnt + CW'(1);
          end else if (r_idle == LP_IDLE_LAST) begin
            r_to    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_idle <= r_idle + IW'(1);
          end
        end
        ST_SWAP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.start0  = r_start0;
  assign bus.start1  = r_start1;
  assign bus.rd_bank = r_bank;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.overrun = r_over;
  assign bus.timeout = r_to;
endmodule

// File: tb/tb_ca_line_sched.sv
// Randomised bench for ca_line_sched: cycle model from the line-refill rules plus directed literal checks.
module tb_ca_line_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ca_line_sched_if #(.AW(8), .DW(16)) bus ();

  ca_line_sched #(.WORDS(160), .AW(8), .DW(16), .TIMEOUT(255)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit en_cmp = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 start, 2 fill, 3 swap.
  int          m_phase = 0;
  bit          m_g = 0, m_mode = 0, m_rr = 0, m_bank = 0;
  int          m_cnt = 0, m_idle = 0;
  bit          t_wr;
  int          t_a;
  logic [15:0] t_d;
  logic        e_start0 = 0, e_start1 = 0, e_we = 0, e_busy = 0, e_done = 0;
  logic        e_over = 0, e_to = 0, e_bank = 0;
  logic [8:0]  e_addr = '0;
  logic [15:0] e_wdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_g = 0; m_mode = 0; m_rr = 0; m_bank = 0; m_cnt = 0; m_idle = 0;
      e_start0 = 0; e_start1 = 0; e_we = 0; e_busy = 0; e_done = 0;
      e_over = 0; e_to = 0; e_bank = 0; e_addr = '0; e_wdata = '0;
    end else begin
      e_start0 = 0; e_start1 = 0; e_we = 0; e_done = 0; e_to = 0;
      e_over = bus.line_req && (m_phase != 0);
      case (m_phase)
        0: if (bus.line_req) begin
          m_g = bus.sel_mode ? m_rr : bus.gen_sel;
          m_mode = bus.sel_mode;
          m_cnt = 0; m_idle = 0; m_phase = 1;
          if (m_g) e_start1 = 1; else e_start0 = 1;
        end
        1: m_phase = 2;
        2: if (m_cnt == 160) begin
          m_phase = 3; e_done = 1; m_bank = ~m_bank;
          if (m_mode) m_rr = ~m_rr;
        end else begin
          t_wr = m_g ? bus.write1 : bus.write0;
          t_a  = m_g ? int'(bus.waddr1) : int'(bus.waddr0);
          t_d  = m_g ? bus.wdata1 : bus.wdata0;
          if (t_wr) begin
            m_idle = 0;
            if (t_a < 160) begin
              e_we = 1; e_addr = {~m_bank, 8'(t_a)}; e_wdata = t_d; m_cnt++;
            end
          end else begin
            m_idle++;
            if (m_idle == 255) begin e_to = 1; m_phase = 0; end
          end
        end
        3: m_phase = 0;
        default: m_phase = 0;
      endcase
      e_busy = (m_phase != 0);
      e_bank = m_bank;
    end
  end

  int n_we, n_msb1, n_bad, n_s0, n_s1, n_done, n_over, n_to;

  always @(negedge clk) begin
    if (en_cmp) begin
      check("start0", bus.start0, e_start0);
      check("start1", bus.start1, e_start1);
      check("mem_we", bus.mem_we, e_we);
      check("rd_bank", bus.rd_bank, e_bank);
      check("busy", bus.busy, e_busy);
      check("done", bus.done, e_done);
      check("overrun", bus.overrun, e_over);
      check("timeout", bus.timeout, e_to);
      if (e_we || !rst_n) begin
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_wdata", bus.mem_wdata, e_wdata);
      end
      if (bus.mem_we) begin
        n_we++;
        if (bus.mem_addr[8]) n_msb1++;
        if (bus.mem_addr[7:0] >= 8'd160) n_bad++;
      end
      if (bus.start0) n_s0++;
      if (bus.start1) n_s1++;
      if (bus.done) n_done++;
      if (bus.overrun) n_over++;
      if (bus.timeout) n_to++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    n_we = 0; n_msb1 = 0; n_bad = 0; n_s0 = 0; n_s1 = 0; n_done = 0; n_over = 0; n_to = 0;
  endtask

  task automatic clr_wr();
    bus.write0 = 0; bus.write1 = 0;
  endtask

  task automatic drive(input bit gi, input int a, input logic [15:0] d);
    if (!gi) begin bus.write0 = 1; bus.waddr0 = 8'(a); bus.wdata0 = d; end
    else     begin bus.write1 = 1; bus.waddr1 = 8'(a); bus.wdata1 = d; end
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    clr_cnt();
  endtask

  task automatic do_line(input int n_good, input bit seq, input bit noise, input bit bad,
                         input bit rq_fill, input bit rq_swap);
    int  sent;
    int  guard;
    bit  g;
    bit  fired;
    bus.line_req = 1; tick(); bus.line_req = 0;
    g = m_g;
    tick();
    sent = 0; fired = 0;
    while (sent < n_good) begin
      clr_wr();
      bus.line_req = 0;
      if (rq_fill && !fired && sent == 50) begin bus.line_req = 1; fired = 1; end
      if ($urandom_range(0, 3) == 0) begin
        if (noise) drive(~g, $urandom_range(0, 159), 16'($urandom));
        if (bad && $urandom_range(0, 1) == 1) drive(g, $urandom_range(160, 255), 16'($urandom));
      end else begin
        drive(g, seq ? sent : $urandom_range(0, 159), 16'($urandom));
        sent++;
        if (noise && $urandom_range(0, 1) == 1) drive(~g, $urandom_range(0, 159), 16'($urandom));
      end
      tick();
    end
    clr_wr(); bus.line_req = 0;
    guard = 0;
    while (m_phase == 2 && guard < 400) begin tick(); guard++; end
    if (rq_swap && m_phase == 3) begin bus.line_req = 1; tick(); bus.line_req = 0; end
    while (m_phase != 0 && guard < 400) begin tick(); guard++; end
    if (m_phase != 0) begin
      checks++; errors++;
      $display("FAIL line_end_bound act=phase%0d exp=idle", m_phase);
    end
    tick();
  endtask

  initial begin
    bus.line_req = 0; bus.sel_mode = 0; bus.gen_sel = 0;
    bus.write0 = 0; bus.write1 = 0;
    bus.waddr0 = '0; bus.waddr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    #2;
    do_reset();
    en_cmp = 1;
    check("rst_rd_bank", bus.rd_bank, 0);
    check("rst_busy", bus.busy, 0);

    // 1: fixed gen0, sequential addresses
    do_line(160, 1, 0, 0, 0, 0);
    check("t1_start0", n_s0, 1);
    check("t1_start1", n_s1, 0);
    check("t1_we", n_we, 160);
    check("t1_msb1", n_msb1, 160);
    check("t1_done", n_done, 1);
    check("t1_rd_bank", bus.rd_bank, 1);

    // 2: round-robin from reset -> grants 0,1,0 into banks 1,0,1
    do_reset();
    bus.sel_mode = 1;
    clr_cnt(); do_line(160, 0, 0, 0, 0, 0);
    check("t2a_start0", n_s0, 1); check("t2a_msb1", n_msb1, 160);
    clr_cnt(); do_line(160, 0, 0, 0, 0, 0);
    check("t2b_start1", n_s1, 1); check("t2b_msb1", n_msb1, 0); check("t2b_we", n_we, 160);
    clr_cnt(); do_line(160, 0, 0, 0, 0, 0);
    check("t2c_start0", n_s0, 1); check("t2c_msb1", n_msb1, 160);

    // 3: requests during FILL and on the SWAP cycle are dropped
    do_reset();
    bus.sel_mode = 0; bus.gen_sel = 1;
    do_line(160, 0, 0, 0, 1, 1);
    check("t3_overrun", n_over, 2);
    check("t3_start1", n_s1, 1);
    check("t3_start0", n_s0, 0);
    check("t3_done", n_done, 1);

    // 4: stalled burst times out, no swap, RR pointer kept
    do_reset();
    bus.sel_mode = 1;
    do_line(100, 0, 0, 0, 0, 0);
    check("t4_timeout", n_to, 1);
    check("t4_done", n_done, 0);
    check("t4_rd_bank", bus.rd_bank, 0);
    clr_cnt(); do_line(160, 0, 0, 0, 0, 0);
    check("t4_regrant0", n_s0, 1);
    check("t4_regrant1", n_s1, 0);

    // 5: other-generator noise and out-of-range addresses never reach RAM
    do_reset();
    bus.sel_mode = 0; bus.gen_sel = 0;
    do_line(160, 0, 1, 1, 0, 0);
    check("t5_we", n_we, 160);
    check("t5_bad", n_bad, 0);
    check("t5_done", n_done, 1);

    // 6: reset in the middle of a burst
    do_reset();
    do_line(160, 0, 0, 0, 0, 0);
    clr_cnt();
    bus.line_req = 1; tick(); bus.line_req = 0; tick();
    for (int i = 0; i < 80; i++) begin clr_wr(); drive(0, i, 16'($urandom)); tick(); end
    clr_wr();
    rst_n = 0;
    #1;
    check("t6_we", bus.mem_we, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_rd_bank", bus.rd_bank, 0);
    check("t6_addr", bus.mem_addr, 0);
    check("t6_wdata", bus.mem_wdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick(); tick();
    check("t6_no_done", n_done, 0);
    check("t6_bank_after", bus.rd_bank, 0);

    // Random lines in both modes
    for (int k = 0; k < 6; k++) begin
      bus.sel_mode = 1'($urandom_range(0, 1));
      bus.gen_sel  = 1'($urandom_range(0, 1));
      do_line(($urandom_range(0, 4) == 0) ? 120 : 160, 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    en_cmp = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
